// File: rtl/pattern_history_table_if.sv
// Signal bundle between the fetch/EX pipeline and the local-predictor pattern history table.
interface pattern_history_table_if #(
  parameter int HIST_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
);
  logic [31:0]           PC_Plus4;
  logic [HIST_WIDTH-1:0] Rhistory;
  logic [31:0]           ID_EX_PC;
  logic [HIST_WIDTH-1:0] ID_EX_History;
  logic                  ID_EX_Branch;
  logic                  ID_EX_BPred;
  logic                  ID_EX_BPredValid;
  logic                  PCSrc;
  logic                  BPred;
  logic                  BPredValid;
  logic                  Mispredict;
  logic                  init_busy;
  logic [CNT_WIDTH-1:0]  branch_count;
  logic [CNT_WIDTH-1:0]  mispredict_count;

  modport master (
    output PC_Plus4, Rhistory, ID_EX_PC, ID_EX_History, ID_EX_Branch,
           ID_EX_BPred, ID_EX_BPredValid, PCSrc,
    input  BPred, BPredValid, Mispredict, init_busy, branch_count, mispredict_count
  );

  modport slave (
    input  PC_Plus4, Rhistory, ID_EX_PC, ID_EX_History, ID_EX_Branch,
           ID_EX_BPred, ID_EX_BPredValid, PCSrc,
    output BPred, BPredValid, Mispredict, init_busy, branch_count, mispredict_count
  );
endinterface

// File: rtl/pattern_history_table.sv
// Second-level table of 2-bit saturating counters indexed by {PC bits, local history};
// predicts at fetch, trains in EX, and keeps saturating branch/mispredict statistics.
module pattern_history_table #(
  parameter int PC_BITS    = 4,
  parameter int HIST_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic clk,
  input  logic reset,
  pattern_history_table_if.slave bus
);
  localparam int IDX_WIDTH = PC_BITS + HIST_WIDTH;
  localparam int DEPTH     = 1 << IDX_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic [1:0]            table_q [DEPTH];
  logic [CNT_WIDTH-1:0]  branch_q, mispredict_q;

  logic [IDX_WIDTH-1:0]  rindex, windex;
  logic [1:0]            train_val;
  logic [1:0]            read_val;
  logic                  train_en;
  logic                  mispredict;

  assign rindex = {bus.PC_Plus4[PC_BITS+1:2], bus.Rhistory};
  assign windex = {bus.ID_EX_PC[PC_BITS+1:2], bus.ID_EX_History};

  // Upper and lower PC bits do not take part in indexing; aliasing is intended.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.PC_Plus4[31:PC_BITS+2], bus.PC_Plus4[1:0],
                            bus.ID_EX_PC[31:PC_BITS+2], bus.ID_EX_PC[1:0]};

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    train_en   = 1'b0;
    mispredict = 1'b0;
    train_val  = table_q[windex];
    read_val   = table_q[rindex];
    bus.BPred      = 1'b0;
    bus.BPredValid = 1'b0;
    bus.init_busy  = 1'b1;

    if (bus.PCSrc) begin
      if (table_q[windex] != 2'b11) train_val = table_q[windex] + 2'b01;
    end else begin
      if (table_q[windex] != 2'b00) train_val = table_q[windex] - 2'b01;
    end

    unique case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_WIDTH'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        train_en   = bus.ID_EX_Branch;
        mispredict = bus.ID_EX_Branch &&
                     (bus.ID_EX_BPredValid ? (bus.ID_EX_BPred != bus.PCSrc) : bus.PCSrc);
        // A same-cycle training write to the read index must be visible to the prediction.
        if (train_en && (windex == rindex)) read_val = train_val;
        bus.BPred      = read_val[1];
        bus.BPredValid = 1'b1;
        bus.init_busy  = 1'b0;
      end
      default: state_d = INIT;
    endcase
  end

  assign bus.Mispredict       = mispredict;
  assign bus.branch_count     = branch_q;
  assign bus.mispredict_count = mispredict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= 2'b00;
    end else if (state_q == INIT) begin
      table_q[ptr_q] <= 2'b01;
    end else if (train_en) begin
      table_q[windex] <= train_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_q     <= '0;
      mispredict_q <= '0;
    end else begin
      if (train_en && (branch_q != '1)) branch_q <= branch_q + 1'b1;
      if (mispredict && (mispredict_q != '1)) mispredict_q <= mispredict_q + 1'b1;
    end
  end
endmodule
